id_ex_hazard_reg: RTL and testbench

//  ID/EX pipeline register for the 16-bit, 8-register pipelined core; feeds the EX-stage ALU operand/dest muxes.

---
 rtl/id_ex_hazard_reg_pkg.sv | 21 ++
 rtl/id_ex_hazard_reg_fwd_select.sv | 29 ++
 rtl/id_ex_hazard_reg.sv | 124 ++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared constants and types for the ID/EX pipeline register with hazard and forwarding logic.
package id_ex_hazard_reg_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int REG_AW_DEFAULT = 3;

    // EX operand select encodings
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic regDst;
        logic aluSrc;
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memToReg;
    } ctrl_t;

endpackage

// File: rtl/id_ex_hazard_reg_fwd_select.sv
// Forwarding select for one source operand, evaluated in ID for the instruction's next EX cycle.
module fwd_select
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] exDest,
    input  logic              exRegWrite,
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] memDestReg,
    input  logic              memRegWrite,
    output logic [1:0]        fwdSel
);

    // The EX producer is checked first so it wins over an older MEM producer;
    // a load in EX is excluded because its data is not ready from MEM's ALU output.
    always_comb begin
        fwdSel = FWD_REG;
        if (src != '0) begin
            if (exRegWrite && (exDest == src) && !exMemRead) begin
                fwdSel = FWD_MEM;
            end else if (memRegWrite && (memDestReg == src)) begin
                fwdSel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register: load-use stall detection, bubble insertion and registered forwarding selects.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_dst,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic [REG_AW-1:0] mem_dest_reg,
    input  logic              mem_reg_write,
    output logic              stall_id,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_read_data1,
    output logic [DATA_W-1:0] ex_read_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    ctrl_t             exCtrl;
    ctrl_t             idCtrl;
    logic [REG_AW-1:0] exDest;
    logic              loadUse;
    logic              bubble;
    logic [1:0]        nextFwdA;
    logic [1:0]        nextFwdB;

    assign idCtrl = '{regDst:   id_reg_dst,
                      aluSrc:   id_alu_src,
                      regWrite: id_reg_write,
                      memRead:  id_mem_read,
                      memWrite: id_mem_write,
                      memToReg: id_mem_to_reg};

    // Same destination choice the EX-stage mux makes
    assign exDest = exCtrl.regDst ? ex_rd : ex_rt;

    assign loadUse = exCtrl.memRead && exCtrl.regWrite && (exDest != '0) &&
                     ((exDest == id_rs) || (id_uses_rt && (exDest == id_rt)));

    // A flushed instruction never executes, so it cannot cause a stall
    assign stall_id = loadUse && !flush && !rst;
    assign bubble   = flush || loadUse;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src         (id_rs),
        .exDest      (exDest),
        .exRegWrite  (exCtrl.regWrite),
        .exMemRead   (exCtrl.memRead),
        .memDestReg  (mem_dest_reg),
        .memRegWrite (mem_reg_write),
        .fwdSel      (nextFwdA)
    );

    // rt is forwarded unconditionally; ALUSrc masks it downstream when unused
    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src         (id_rt),
        .exDest      (exDest),
        .exRegWrite  (exCtrl.regWrite),
        .exMemRead   (exCtrl.memRead),
        .memDestReg  (mem_dest_reg),
        .memRegWrite (mem_reg_write),
        .fwdSel      (nextFwdB)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            exCtrl        <= '0;
            forward_a     <= FWD_REG;
            forward_b     <= FWD_REG;
        end else if (!hold) begin
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_read_data1 <= id_read_data1;
            ex_read_data2 <= id_read_data2;
            ex_imm        <= id_imm;
            if (bubble) begin
                exCtrl    <= '0;
                forward_a <= FWD_REG;
                forward_b <= FWD_REG;
            end else begin
                exCtrl    <= idCtrl;
                forward_a <= nextFwdA;
                forward_b <= nextFwdB;
            end
        end
    end

    assign ex_reg_dst    = exCtrl.regDst;
    assign ex_alu_src    = exCtrl.aluSrc;
    assign ex_reg_write  = exCtrl.regWrite;
    assign ex_mem_read   = exCtrl.memRead;
    assign ex_mem_write  = exCtrl.memWrite;
    assign ex_mem_to_reg = exCtrl.memToReg;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed hazard scenarios then randomized traffic against a slot-level model.
module tb_id_ex_hazard_reg;

    localparam int DW = 16;
    localparam int AW = 3;

    // Control vector order: {reg_dst, alu_src, reg_write, mem_read, mem_write, mem_to_reg}
    localparam logic [5:0] CTL_ADD   = 6'b101000;
    localparam logic [5:0] CTL_ADDNW = 6'b100000;
    localparam logic [5:0] CTL_LW    = 6'b011101;

    logic          clk = 1'b0;
    logic          rst, hold, flush;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rt;
    logic [DW-1:0] id_read_data1, id_read_data2, id_imm;
    logic          id_reg_dst, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [AW-1:0] mem_dest_reg;
    logic          mem_reg_write;
    logic          stall_id;
    logic [AW-1:0] ex_rt, ex_rd;
    logic [DW-1:0] ex_read_data1, ex_read_data2, ex_imm;
    logic          ex_reg_dst, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [1:0]    forward_a, forward_b;

    int checks   = 0;
    int failures = 0;

    // Model of the instruction slot sitting in EX
    logic [AW-1:0] mRt = '0, mRd = '0;
    logic [DW-1:0] mD1 = '0, mD2 = '0, mImm = '0;
    logic [5:0]    mCtl = '0;
    logic [1:0]    mFa = '0, mFb = '0;
    bit            mKnown = 1'b1;

    always #5 clk = ~clk;

    id_ex_hazard_reg dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_dest_reg(mem_dest_reg), .mem_reg_write(mem_reg_write),
        .stall_id(stall_id), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2), .ex_imm(ex_imm),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .forward_a(forward_a), .forward_b(forward_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] modelDest();
        return mCtl[5] ? mRd : mRt;
    endfunction

    // Where will source s find its value next cycle, given who is in EX and MEM now
    function automatic logic [1:0] refFwd(input logic [AW-1:0] s);
        if (s == '0) return 2'b00;
        if (mCtl[3] && !mCtl[2] && modelDest() == s) return 2'b10;
        if (mem_reg_write && mem_dest_reg == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit refLoadUse();
        logic [AW-1:0] d;
        d = modelDest();
        return mCtl[2] && mCtl[3] && (d != '0) &&
               ((d == id_rs) || (id_uses_rt && (d == id_rt)));
    endfunction

    task automatic setId(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic usesRt, input logic [5:0] ctl);
        id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = usesRt;
        {id_reg_dst, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = ctl;
        id_read_data1 = DW'($urandom);
        id_read_data2 = DW'($urandom);
        id_imm        = DW'($urandom);
    endtask

    task automatic chkOutputs();
        chk("ex_reg_dst",    32'(ex_reg_dst),    32'(mCtl[5]));
        chk("ex_alu_src",    32'(ex_alu_src),    32'(mCtl[4]));
        chk("ex_reg_write",  32'(ex_reg_write),  32'(mCtl[3]));
        chk("ex_mem_read",   32'(ex_mem_read),   32'(mCtl[2]));
        chk("ex_mem_write",  32'(ex_mem_write),  32'(mCtl[1]));
        chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(mCtl[0]));
        chk("forward_a",     32'(forward_a),     32'(mFa));
        chk("forward_b",     32'(forward_b),     32'(mFb));
        if (mKnown) begin
            chk("ex_rt",         32'(ex_rt),         32'(mRt));
            chk("ex_rd",         32'(ex_rd),         32'(mRd));
            chk("ex_read_data1", 32'(ex_read_data1), 32'(mD1));
            chk("ex_read_data2", 32'(ex_read_data2), 32'(mD2));
            chk("ex_imm",        32'(ex_imm),        32'(mImm));
        end
    endtask

    // Check the combinational stall, advance the model, clock, then check registered outputs
    task automatic cycle();
        logic [1:0] nFa, nFb;
        bit         lu;
        #1;
        lu  = refLoadUse();
        chk("stall_id", 32'(stall_id), 32'(lu && !flush && !rst));
        nFa = refFwd(id_rs);
        nFb = refFwd(id_rt);
        if (rst) begin
            {mRt, mRd, mD1, mD2, mImm, mCtl, mFa, mFb} = '0;
            mKnown = 1'b1;
        end else if (!hold) begin
            if (flush || lu) begin
                mCtl = '0; mFa = 2'b00; mFb = 2'b00;
                mKnown = 1'b0;
            end else begin
                mRt = id_rt; mRd = id_rd; mD1 = id_read_data1; mD2 = id_read_data2; mImm = id_imm;
                mCtl = {id_reg_dst, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg};
                mFa = nFa; mFb = nFb;
                mKnown = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chkOutputs();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        mem_dest_reg = 3'd6; mem_reg_write = 1'b1;
        setId(3'd1, 3'd2, 3'd3, 1'b1, 6'b111111);

        // Reset with busy ID inputs
        cycle();
        cycle();
        chk("rst_forward_a", 32'(forward_a), 32'd0);
        chk("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
        rst = 1'b0;
        mem_reg_write = 1'b0;

        // EX producer forwards to both sources
        setId(3'd1, 3'd2, 3'd3, 1'b1, CTL_ADD);
        cycle();
        setId(3'd3, 3'd3, 3'd4, 1'b1, CTL_ADD);
        cycle();
        chk("ex_fwd_a", 32'(forward_a), 32'b10);
        chk("ex_fwd_b", 32'(forward_b), 32'b10);

        // EX producer beats MEM producer; without EX write, MEM producer is used
        setId(3'd1, 3'd2, 3'd5, 1'b1, CTL_ADD);
        cycle();
        mem_dest_reg = 3'd5; mem_reg_write = 1'b1;
        setId(3'd5, 3'd1, 3'd6, 1'b1, CTL_ADDNW);
        cycle();
        chk("ex_over_mem", 32'(forward_a), 32'b10);
        setId(3'd5, 3'd1, 3'd7, 1'b1, CTL_ADD);
        cycle();
        chk("mem_only", 32'(forward_a), 32'b01);
        mem_reg_write = 1'b0;

        // Load-use: stall and bubble, then forward from WB once the load reaches MEM
        setId(3'd1, 3'd2, 3'd0, 1'b1, CTL_LW);
        cycle();
        setId(3'd2, 3'd4, 3'd3, 1'b1, CTL_ADD);
        #1;
        chk("lu_stall", 32'(stall_id), 32'd1);
        cycle();
        chk("lu_bubble", 32'(ex_reg_write), 32'd0);
        mem_dest_reg = 3'd2; mem_reg_write = 1'b1;
        #1;
        chk("lu_release", 32'(stall_id), 32'd0);
        cycle();
        chk("lu_fwd_wb", 32'(forward_a), 32'b01);
        mem_reg_write = 1'b0;

        // Flush masks the stall; then a hold freezes everything for three cycles
        setId(3'd1, 3'd2, 3'd0, 1'b1, CTL_LW);
        cycle();
        setId(3'd2, 3'd4, 3'd3, 1'b1, CTL_ADD);
        flush = 1'b1;
        #1;
        chk("flush_no_stall", 32'(stall_id), 32'd0);
        cycle();
        chk("flush_bubble", 32'(ex_reg_write), 32'd0);
        flush = 1'b0;
        setId(3'd3, 3'd4, 3'd5, 1'b1, CTL_ADD);
        cycle();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setId(3'(i + 1), 3'(i + 2), 3'(i + 3), 1'b1, 6'(i * 21 + 7));
            cycle();
        end
        hold = 1'b0;

        // r0 is never forwarded or stalled on; an unused rt cannot cause a stall
        setId(3'd1, 3'd2, 3'd0, 1'b1, 6'b101100);
        cycle();
        setId(3'd0, 3'd0, 3'd1, 1'b1, CTL_ADD);
        mem_dest_reg = 3'd0; mem_reg_write = 1'b1;
        #1;
        chk("r0_no_stall", 32'(stall_id), 32'd0);
        cycle();
        chk("r0_fwd_a", 32'(forward_a), 32'b00);
        chk("r0_fwd_b", 32'(forward_b), 32'b00);
        mem_reg_write = 1'b0;
        setId(3'd1, 3'd2, 3'd0, 1'b1, CTL_LW);
        cycle();
        setId(3'd1, 3'd2, 3'd3, 1'b0, CTL_ADD);
        #1;
        chk("no_uses_rt", 32'(stall_id), 32'd0);
        cycle();

        // Reset while a stall is pending
        setId(3'd1, 3'd2, 3'd0, 1'b1, CTL_LW);
        cycle();
        setId(3'd2, 3'd2, 3'd3, 1'b1, CTL_ADD);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Randomized traffic over a small register set so hazards are frequent
        for (int n = 0; n < 600; n++) begin
            logic [5:0] ctl;
            ctl = 6'($urandom);
            if (ctl[2] && $urandom_range(0, 3) != 0) ctl[3] = 1'b1;
            setId(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  1'($urandom), ctl);
            mem_dest_reg  = 3'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom);
            rst   = ($urandom_range(0, 49) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
